// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module  : pipeline_ctrl
// Purpose : 5-stage pipeline sequencing and hazard controller (stalls, flushes,
//           halt drain) with a saturating stall-cycle counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
   parameter int CNT_W = 16,
   parameter int REG_W = 5
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_req,
   input  logic             ex_taken,
   input  logic             idex_dREN,
   input  logic [REG_W-1:0] idex_rd,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             id_halt,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_en,
   output logic             memwb_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t state;
   logic   drain_pend;

   logic   dstall;
   logic   load_use;
   logic   hz_stall;
   logic   in_drain;
   logic   drain_go;

   // While parked in DWAIT the outstanding access is the one being waited on,
   // so only dhit matters there.
   assign dstall   = (state == DWAIT) ? !dhit : (mem_req & !dhit);
   assign load_use = idex_dREN && (idex_rd != '0) &&
                     ((idex_rd == id_rs) || (id_uses_rt && (idex_rd == id_rt)));
   assign in_drain = (state == DRAIN) || ((state == DWAIT) && drain_pend);
   // Hazard-caused PC freezes only; the drain-forced freeze is not counted.
   assign hz_stall = dstall || (!ex_taken && (load_use || !ihit));
   assign drain_go = id_halt && !dstall && !ex_taken && !load_use && ihit;

   always_comb begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_en     = 1'b1;
      idex_flush  = 1'b0;
      exmem_en    = 1'b1;
      exmem_flush = 1'b0;
      memwb_en    = 1'b1;
      memwb_flush = 1'b0;
      if (state == HALTED) begin
         pc_en    = 1'b0;
         ifid_en  = 1'b0;
         idex_en  = 1'b0;
         exmem_en = 1'b0;
         memwb_en = 1'b0;
      end else begin
         if (dstall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
         end else if (ex_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end else if (!ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
         end
         // A taken branch during drain means HALT was wrong-path: the PC must
         // still load the target because the machine resumes fetching.
         if (in_drain && !dstall) begin
            pc_en      = ex_taken;
            ifid_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state      <= RUN;
         drain_pend <= 1'b0;
         halt       <= 1'b0;
         stall_cnt  <= '0;
      end else begin
         if ((state != HALTED) && hz_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_ONE;
         case (state)
            HALTED: begin
               state <= HALTED;
               halt  <= 1'b1;
            end
            default: begin
               if (wb_halt) begin
                  state <= HALTED;
                  halt  <= 1'b1;
               end else if (dstall) begin
                  state      <= DWAIT;
                  drain_pend <= in_drain;
               end else if (in_drain) begin
                  state      <= ex_taken ? RUN : DRAIN;
                  drain_pend <= 1'b0;
               end else begin
                  state      <= drain_go ? DRAIN : RUN;
                  drain_pend <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_ctrl
// Purpose : Table-driven self-checking bench for pipeline_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

   localparam int CNT_W = 16;
   localparam int REG_W = 5;

   // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush}
   localparam logic [8:0] C_ALL = 9'b110101010;
   localparam logic [8:0] C_DST = 9'b000000011;
   localparam logic [8:0] C_BR  = 9'b111111010;
   localparam logic [8:0] C_LU  = 9'b000111010;
   localparam logic [8:0] C_MIS = 9'b011101010;
   localparam logic [8:0] C_DRN = 9'b011101010;
   localparam logic [8:0] C_HLT = 9'b000000000;

   typedef struct {
      logic             ihit, dhit, mem_req, ex_taken, idex_dREN;
      logic [REG_W-1:0] idex_rd, id_rs, id_rt;
      logic             id_uses_rt, id_halt, wb_halt;
      logic [8:0]       ctl;
      logic             hlt;
      int               cnt;
   } vec_t;

   logic CLK = 1'b0;
   logic nRST;
   logic ihit, dhit, mem_req, ex_taken, idex_dREN, id_uses_rt, id_halt, wb_halt;
   logic [REG_W-1:0] idex_rd, id_rs, id_rt;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
   logic [CNT_W-1:0] stall_cnt;

   logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush;
   logic s_exmem_en, s_exmem_flush, s_memwb_en, s_memwb_flush, s_halt;
   logic [2:0] s_stall_cnt;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   pipeline_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .ex_taken(ex_taken), .idex_dREN(idex_dREN), .idex_rd(idex_rd),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_halt(id_halt), .wb_halt(wb_halt), .pc_en(pc_en),
      .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
      .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
      .memwb_en(memwb_en), .memwb_flush(memwb_flush), .halt(halt),
      .stall_cnt(stall_cnt)
   );

   // Narrow-counter instance sharing the stimulus, used for saturation.
   pipeline_ctrl #(.CNT_W(3), .REG_W(REG_W)) dut_s (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
      .ex_taken(ex_taken), .idex_dREN(idex_dREN), .idex_rd(idex_rd),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_halt(id_halt), .wb_halt(wb_halt), .pc_en(s_pc_en),
      .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
      .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .exmem_flush(s_exmem_flush),
      .memwb_en(s_memwb_en), .memwb_flush(s_memwb_flush), .halt(s_halt),
      .stall_cnt(s_stall_cnt)
   );

   function automatic vec_t mkv(input logic ih, dh, mr, et, dr,
                                input int rd, rs, rt,
                                input logic ut, idh, wbh,
                                input logic [8:0] ctl, input logic hl, input int cnt);
      vec_t v;
      v.ihit = ih; v.dhit = dh; v.mem_req = mr; v.ex_taken = et; v.idex_dREN = dr;
      v.idex_rd = REG_W'(rd); v.id_rs = REG_W'(rs); v.id_rt = REG_W'(rt);
      v.id_uses_rt = ut; v.id_halt = idh; v.wb_halt = wbh;
      v.ctl = ctl; v.hlt = hl; v.cnt = cnt;
      return v;
   endfunction

   function automatic vec_t idle(input logic [8:0] ctl, input logic hl, input int cnt);
      return mkv(1, 0, 0, 0, 0, 1, 2, 3, 1, 0, 0, ctl, hl, cnt);
   endfunction

   task automatic drive(input vec_t v);
      ihit = v.ihit; dhit = v.dhit; mem_req = v.mem_req; ex_taken = v.ex_taken;
      idex_dREN = v.idex_dREN; idex_rd = v.idex_rd; id_rs = v.id_rs; id_rt = v.id_rt;
      id_uses_rt = v.id_uses_rt; id_halt = v.id_halt; wb_halt = v.wb_halt;
   endtask

   task automatic step(input vec_t v, input string name);
      logic [8:0] got;
      @(negedge CLK);
      drive(v);
      #1;
      got = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
             exmem_en, exmem_flush, memwb_en, memwb_flush};
      checks++;
      if (got !== v.ctl) begin
         errors++;
         $display("FAIL %s ctl: got %b want %b", name, got, v.ctl);
      end
      checks++;
      if (halt !== v.hlt) begin
         errors++;
         $display("FAIL %s halt: got %b want %b", name, halt, v.hlt);
      end
      checks++;
      if (stall_cnt !== CNT_W'(v.cnt)) begin
         errors++;
         $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, v.cnt);
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      nRST = 1'b0;
      drive(idle(C_ALL, 0, 0));
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      nRST = 1'b1;
   endtask

   vec_t tbl[14];

   initial begin
      nRST = 1'b0;
      drive(idle(C_ALL, 0, 0));

      //          ih dh mr et dr rd rs rt ut idh wbh  ctl   hlt cnt
      tbl[0]  = idle(C_ALL, 0, 0);
      tbl[1]  = mkv(1, 0, 0, 0, 1, 5, 5, 9, 1, 0, 0, C_LU,  0, 0);
      tbl[2]  = idle(C_ALL, 0, 1);
      tbl[3]  = mkv(1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, C_ALL, 0, 1);
      tbl[4]  = mkv(1, 0, 0, 0, 1, 7, 3, 7, 0, 0, 0, C_ALL, 0, 1);
      tbl[5]  = mkv(1, 0, 0, 0, 1, 7, 3, 7, 1, 0, 0, C_LU,  0, 1);
      tbl[6]  = mkv(0, 0, 0, 0, 0, 1, 2, 3, 1, 0, 0, C_MIS, 0, 2);
      tbl[7]  = mkv(1, 0, 1, 0, 0, 1, 2, 3, 1, 0, 0, C_DST, 0, 3);
      tbl[8]  = mkv(1, 0, 1, 0, 0, 1, 2, 3, 1, 0, 0, C_DST, 0, 4);
      tbl[9]  = mkv(1, 0, 1, 0, 0, 1, 2, 3, 1, 0, 0, C_DST, 0, 5);
      tbl[10] = mkv(1, 1, 1, 0, 0, 1, 2, 3, 1, 0, 0, C_ALL, 0, 6);
      tbl[11] = idle(C_ALL, 0, 6);
      tbl[12] = mkv(0, 0, 0, 1, 1, 4, 4, 4, 1, 0, 0, C_BR,  0, 6);
      tbl[13] = idle(C_ALL, 0, 6);

      do_reset();
      for (int i = 0; i < 14; i++) step(tbl[i], $sformatf("vec%0d", i));

      // Halt drain: HALT decoded, three drain cycles, HALT reaches WB, then frozen.
      step(mkv(1, 0, 0, 0, 0, 1, 2, 3, 1, 1, 0, C_ALL, 0, 6), "halt_id");
      step(idle(C_DRN, 0, 6), "drain1");
      step(idle(C_DRN, 0, 6), "drain2");
      step(mkv(1, 0, 0, 0, 0, 1, 2, 3, 1, 0, 1, C_DRN, 0, 6), "drain_wb");
      step(idle(C_HLT, 1, 6), "halted1");
      step(mkv(0, 0, 1, 1, 1, 5, 5, 5, 1, 0, 0, C_HLT, 1, 6), "halted2");

      // Reset in the middle of a dcache wait.
      do_reset();
      step(mkv(1, 0, 1, 0, 0, 1, 2, 3, 1, 0, 0, C_DST, 0, 0), "dw_pre1");
      step(mkv(1, 0, 1, 0, 0, 1, 2, 3, 1, 0, 0, C_DST, 0, 1), "dw_pre2");
      do_reset();
      step(idle(C_ALL, 0, 0), "post_rst");

      // Counter saturation on the 3-bit instance.
      for (int i = 0; i < 9; i++)
         step(mkv(0, 0, 0, 0, 0, 1, 2, 3, 1, 0, 0, C_MIS, 0, i), $sformatf("miss%0d", i));
      step(idle(C_ALL, 0, 9), "sat_main");
      checks++;
      if (s_stall_cnt !== 3'd7) begin
         errors++;
         $display("FAIL sat_narrow stall_cnt: got %0d want 7", s_stall_cnt);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central sequencing and hazard controller for the 5-stage pipeline.
- Drives enable (en) and flush for the PC and for the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Resolves icache/dcache wait stalls, load-use hazards, taken branches/jumps and halt drain.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- CNT_W, 16, width of stall_cnt.
- REG_W, 5, width of register indices.

Ports:
- CLK  input  1  system clock.
- nRST  input  1  synchronous active-low reset.
- ihit  input  1  icache returned the instruction this cycle.
- dhit  input  1  dcache completed the MEM-stage access this cycle.
- mem_req  input  1  EX/MEM latch holds a load or store (dREN_o|dWEN_o).
- ex_taken  input  1  EX stage resolved a taken branch or jump (pcSrc_o!=0).
- idex_dREN  input  1  ID/EX latch holds a load.
- idex_rd  input  REG_W  destination register of ID/EX instruction.
- id_rs, id_rt  input  REG_W  source registers of the IF/ID instruction.
- id_uses_rt  input  1  IF/ID instruction reads rt.
- id_halt  input  1  IF/ID instruction is HALT.
- wb_halt  input  1  MEM/WB latch holds HALT.
- pc_en  output  1  PC update enable.
- ifid_en, ifid_flush  output  1 each  IF/ID controls.
- idex_en, idex_flush  output  1 each  ID/EX controls.
- exmem_en, exmem_flush  output  1 each  EX/MEM controls.
- memwb_en, memwb_flush  output  1 each  MEM/WB controls.
- halt  output  1  registered sticky processor halt.
- stall_cnt  output  CNT_W  registered count of cycles with pc_en=0 while not halted.

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is synchronous and active-low, sampled on the CLK rising edge.
- On reset: state=RUN, halt=0, stall_cnt=0.
- Latch control outputs are combinational from state and inputs, so they act in the same cycle.
- Flush has priority over en inside each latch; flush inserts a NOP bubble.
- Defaults (no hazard): every en=1, every flush=0.
- States: RUN, DWAIT, DRAIN, HALTED.
- RUN/DRAIN conditions, evaluated in this priority order:
  1. dstall = mem_req & !dhit:
     - pc_en, ifid_en, idex_en and exmem_en are all 0.
     - memwb_flush=1.
     - Next state is DWAIT.
  2. ex_taken:
     - pc_en=1 (PC loads target).
     - ifid_flush=1 and idex_flush=1; the later stages advance.
     - Load-use and ihit conditions are ignored this cycle, because those instructions are wrong-path.
  3. Load-use hazard: idex_dREN & idex_rd!=0 & (idex_rd==id_rs | (id_uses_rt & idex_rd==id_rt)):
     - pc_en=0, ifid_en=0.
     - idex_flush=1.
     - EX/MEM and MEM/WB advance.
     - Exactly one bubble; the condition clears next cycle.
  4. !ihit:
     - pc_en=0, ifid_flush=1.
     - The later stages advance.
- DWAIT:
  - Outputs equal case 1 while dhit=0.
  - On the dhit=1 cycle, evaluate as RUN with dstall=0, then go to RUN (or DRAIN if a drain was pending).
- RUN to DRAIN: when id_halt=1, ifid_en is not blocked this cycle, and the hazard priority does not flush IF/ID.
- DRAIN:
  - Same priority rules as RUN, plus pc_en=0 and ifid_flush=1 every cycle, so no new fetch enters.
  - Counting ignores DRAIN-forced stalls (stall_cnt does not increment for them).
  - On wb_halt=1, go to HALTED. If ex_taken occurs in DRAIN (HALT was wrong-path), return to RUN.
- HALTED: all en=0, all flush=0, halt=1 from the cycle after entry until reset.
- stall_cnt: increments when pc_en=0 in RUN/DWAIT; saturates at 2^CNT_W-1 (no wrap).
- Reset mid-operation (for example during DWAIT) returns to RUN immediately, with no residual freeze.
- wb_halt in RUN (no DRAIN) also goes to HALTED.

Test Plan:
- Load-use: idex_dREN=1, idex_rd=5, id_rs=5, ihit=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. Next cycle (idex_dREN=0) all en=1. stall_cnt 0->1.
- idex_rd=0 with id_rs=0 and load in EX -> no stall. Also id_rt match with id_uses_rt=0 -> no stall.
- Dcache wait: mem_req=1 with dhit=0 for 3 cycles, then 1 -> three cycles of all front en=0 and memwb_flush=1. On the dhit cycle all en=1, then state RUN. stall_cnt=3.
- Branch plus load-use plus !ihit in the same cycle -> pc_en=1, ifid_flush=1, idex_flush=1, no stall count.
- Halt: id_halt=1, then wb_halt=1 three cycles later -> DRAIN with pc_en=0 and ifid_flush=1. halt=1 the cycle after wb_halt and stays 1. All en=0 thereafter.
- nRST=0 during DWAIT, then release -> state RUN, halt=0, stall_cnt=0, all en=1 with idle inputs (ihit=1, mem_req=0).
